// File: rtl/instr_prefetch_pkg.sv
// Shared bus types, FSM encoding and PC helper for the instruction prefetcher.
// Types only, no logic: zero latency, no backpressure.
`ifndef PC_RANGE
`define PC_RANGE 31:0
`endif
`ifndef DATA_RANGE
`define DATA_RANGE 31:0
`endif

package instr_prefetch_pkg;

    typedef struct packed {
        logic              read;
        logic [`PC_RANGE]  address;
        logic [3:0]        byte_enable;
        logic              write;
        logic [`DATA_RANGE] writedata;
    } avalon_req_t;

    typedef struct packed {
        logic              waitrequest;
        logic              readdatavalid;
        logic [`DATA_RANGE] readdata;
    } avalon_resp_t;

    typedef enum logic {RUN, REDIR} pf_state_t;

    localparam logic [3:0] BYTE_EN_ALL = 4'b1111;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with clear; head visible combinationally, one-cycle push-to-pop.
// No internal backpressure: the caller must never push when full or pop when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= push_dat;
    end

    assign pop_dat = mem[rd_ptr];

endmodule

// File: rtl/instr_prefetch.sv
// Avalon instruction prefetcher: credit-limited reads into a small queue, flush on branch.
// Accept->fetch_valid = bus latency + 1; issue stalls when in-flight + queued reaches FIFO_DEPTH.
module instr_prefetch
    import instr_prefetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    output avalon_req_t        ibus_avalon_req,
    input  avalon_resp_t       ibus_avalon_resp,
    input  logic               branch_take,
    input  logic [`PC_RANGE]   branch_pc,
    output logic               fetch_valid,
    input  logic               fetch_ready,
    output logic [`PC_RANGE]   fetch_pc,
    output logic [`DATA_RANGE] fetch_instruction
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    pf_state_t     state, state_nxt;
    logic [31:0]   fetch_pc_reg, pc_nxt;
    logic [31:0]   redir_pc, redir_nxt;
    logic [CW-1:0] outstanding, out_nxt;
    logic [CW-1:0] discard_cnt, discard_nxt;
    logic [CW-1:0] fifo_count, tag_count;
    logic [CW:0]   inflight;
    logic          held_q, read, accept, held, resp_vld, dropping;
    logic          keep_resp, tag_push, tag_pop, fifo_pop;
    logic [31:0]   tag_head;
    logic [63:0]   head_dat;

    assign inflight = {1'b0, outstanding} + {1'b0, fifo_count};
    // A request stalled by waitrequest stays on the bus regardless of credit.
    assign read     = !rst && (held_q || int'(inflight) < FIFO_DEPTH);
    assign accept   = read && !ibus_avalon_resp.waitrequest;
    assign held     = read && ibus_avalon_resp.waitrequest;
    assign resp_vld = ibus_avalon_resp.readdatavalid;
    assign dropping = discard_cnt != '0;

    assign keep_resp = resp_vld && !dropping && !branch_take;
    assign tag_push  = accept && state == RUN && !branch_take;
    assign tag_pop   = keep_resp && tag_count != '0;
    assign fifo_pop  = fetch_valid && fetch_ready && !branch_take;
    assign out_nxt   = outstanding + CW'(accept) - CW'(resp_vld);

    always_comb begin
        ibus_avalon_req             = '0;
        ibus_avalon_req.read        = read;
        ibus_avalon_req.address     = fetch_pc_reg;
        ibus_avalon_req.byte_enable = BYTE_EN_ALL;
    end

    // Every response still owed by the bus at a redirect belongs to the old path.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = fetch_pc_reg;
        redir_nxt   = redir_pc;
        discard_nxt = discard_cnt - CW'(resp_vld && dropping);
        if (branch_take) begin
            discard_nxt = out_nxt;
            if (held) begin
                state_nxt = REDIR;
                redir_nxt = branch_pc;
            end else begin
                state_nxt = RUN;
                pc_nxt    = branch_pc;
            end
        end else if (accept) begin
            if (state == REDIR) begin
                state_nxt   = RUN;
                pc_nxt      = redir_pc;
                discard_nxt = discard_nxt + 1'b1;
            end else begin
                pc_nxt = pc_next(fetch_pc_reg);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            fetch_pc_reg <= RESET_PC;
            redir_pc     <= RESET_PC;
            outstanding  <= '0;
            discard_cnt  <= '0;
            held_q       <= 1'b0;
        end else begin
            state        <= state_nxt;
            fetch_pc_reg <= pc_nxt;
            redir_pc     <= redir_nxt;
            outstanding  <= out_nxt;
            discard_cnt  <= discard_nxt;
            held_q       <= held;
        end
    end

    sync_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (branch_take),
        .push     (tag_push),
        .push_dat (fetch_pc_reg),
        .pop      (tag_pop),
        .pop_dat  (tag_head),
        .count    (tag_count)
    );

    sync_fifo #(.WIDTH(64), .DEPTH(FIFO_DEPTH)) u_instr_fifo (
        .clk      (clk),
        .rst      (rst),
        .clear    (branch_take),
        .push     (tag_pop),
        .push_dat ({tag_head, ibus_avalon_resp.readdata}),
        .pop      (fifo_pop),
        .pop_dat  (head_dat),
        .count    (fifo_count)
    );

    assign fetch_valid       = fifo_count != '0;
    assign fetch_pc          = head_dat[63:32];
    assign fetch_instruction = head_dat[31:0];

endmodule
